// File: rtl/lvds_rx_pkg.sv
// Shared LVDS receive definitions: word width, training word, aligner FSM
// state encoding and the sync codes recognised by the downstream word aligner.
package lvds_rx_pkg;

  localparam int unsigned DATA_W = 12;

  // Default training word; all 12 rotations are distinct.
  localparam logic [DATA_W-1:0] TRAIN_WORD_DEF = 12'h0FC;

  // Sync codes shared with the word aligner (SAV/EAV style markers).
  localparam logic [DATA_W-1:0] SYNC_SOF = 12'hAB0;
  localparam logic [DATA_W-1:0] SYNC_SOL = 12'h800;
  localparam logic [DATA_W-1:0] SYNC_EOL = 12'h9D0;
  localparam logic [DATA_W-1:0] SYNC_EOF = 12'hB60;

  typedef enum logic [2:0] {
    IDLE,
    SEARCH,
    VERIFY,
    LOCKED,
    FAIL
  } align_state_t;

  // Next bit offset in the sweep; wraps from DATA_W-1 back to 0.
  function automatic logic [3:0] next_offset(input logic [3:0] off);
    return (off == 4'(DATA_W - 1)) ? 4'd0 : off + 4'd1;
  endfunction

endpackage

// File: rtl/bit_window_mux.sv
// 24-to-12 bit window selector; offsets beyond DATA_W-1 return zero.
module bit_window_mux
  import lvds_rx_pkg::*;
(
  input  logic [2*DATA_W-1:0] cat_i,
  input  logic [3:0]          sel_i,
  output logic [DATA_W-1:0]   window_o
);

  // Pick the 12-bit slice starting at the selected bit offset.
  always_comb begin
    window_o = '0;
    if (sel_i < 4'(DATA_W)) begin
      window_o = cat_i[sel_i +: DATA_W];
    end
  end

endmodule

// File: rtl/lvds_bitslip_align.sv
// Per-lane word-boundary trainer: sweeps a bit offset against the training
// word, freezes it once enough consecutive matches are seen, and forwards
// framed words only while locked.
module lvds_bitslip_align
  import lvds_rx_pkg::*;
#(
  parameter logic [DATA_W-1:0] TRAIN_WORD = TRAIN_WORD_DEF,
  parameter int unsigned       LOCK_COUNT = 8,
  parameter int unsigned       MAX_TRIES  = 48
) (
  input  logic              SDR_CLK,
  input  logic              RST_N,
  input  logic [DATA_W-1:0] raw_12bit,
  input  logic              train_req,
  output logic [DATA_W-1:0] data_12bit,
  output logic              aligned,
  output logic              align_err,
  output logic [3:0]        bit_offset
);

  localparam logic [7:0] LOCK_C = 8'(LOCK_COUNT);
  localparam logic [7:0] MAX_C  = 8'(MAX_TRIES);

  logic [DATA_W-1:0]   raw0_q, raw1_q;
  logic [2*DATA_W-1:0] cat;
  logic [DATA_W-1:0]   window;
  logic                match;
  logic                advance;

  align_state_t      state_q, state_d;
  logic [3:0]        offset_q, offset_d;
  logic [7:0]        try_q, try_d;
  logic [7:0]        match_q, match_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic              aligned_q, aligned_d;
  logic              err_q, err_d;

  assign cat   = {raw0_q, raw1_q};
  assign match = (window == TRAIN_WORD);

  bit_window_mux u_mux (
    .cat_i    (cat),
    .sel_i    (offset_q),
    .window_o (window)
  );

  // Two-word history so any rotation can be cut from consecutive words.
  always_ff @(posedge SDR_CLK or negedge RST_N) begin
    if (!RST_N) begin
      raw0_q <= '0;
      raw1_q <= '0;
    end else begin
      raw0_q <= raw_12bit;
      raw1_q <= raw0_q;
    end
  end

  // Training FSM next-state, counters and output decodes.
  always_comb begin
    state_d  = state_q;
    offset_d = offset_q;
    try_d    = try_q;
    match_d  = match_q;
    advance  = 1'b0;

    if (train_req) begin
      state_d  = SEARCH;
      offset_d = '0;
      try_d    = '0;
      match_d  = '0;
    end else begin
      unique case (state_q)
        SEARCH: begin
          if (match) begin
            if (LOCK_C == 8'd1) begin
              state_d = LOCKED;
            end else begin
              state_d = VERIFY;
              match_d = 8'd1;
            end
          end else begin
            advance = 1'b1;
          end
        end
        VERIFY: begin
          if (match) begin
            match_d = match_q + 8'd1;
            if (match_q + 8'd1 == LOCK_C) begin
              state_d = LOCKED;
            end
          end else begin
            match_d = '0;
            state_d = SEARCH;
            advance = 1'b1;
          end
        end
        IDLE, LOCKED, FAIL: begin
        end
        default: state_d = IDLE;
      endcase
    end

    if (advance) begin
      offset_d = next_offset(offset_q);
      try_d    = try_q + 8'd1;
      if (try_d == MAX_C) begin
        state_d = FAIL;
      end
    end

    aligned_d = (state_d == LOCKED);
    err_d     = (state_d == FAIL);
    // A retrain request blanks data on the same edge that drops aligned.
    data_d    = (state_q == LOCKED && !train_req) ? window : '0;
  end

  // FSM state and registered outputs.
  always_ff @(posedge SDR_CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q   <= IDLE;
      offset_q  <= '0;
      try_q     <= '0;
      match_q   <= '0;
      data_q    <= '0;
      aligned_q <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      offset_q  <= offset_d;
      try_q     <= try_d;
      match_q   <= match_d;
      data_q    <= data_d;
      aligned_q <= aligned_d;
      err_q     <= err_d;
    end
  end

  assign data_12bit = data_q;
  assign aligned    = aligned_q;
  assign align_err  = err_q;
  assign bit_offset = offset_q;

endmodule

// File: tb/tb_lvds_bitslip_align.sv
// Directed bench for lvds_bitslip_align with hand-computed expectations.
module tb_lvds_bitslip_align;

  logic        SDR_CLK;
  logic        RST_N;
  logic [11:0] raw_12bit;
  logic        train_req;
  logic [11:0] data_12bit;
  logic        aligned;
  logic        align_err;
  logic [3:0]  bit_offset;

  int checks = 0;
  int errors = 0;

  lvds_bitslip_align #(
    .TRAIN_WORD (12'h0FC),
    .LOCK_COUNT (8),
    .MAX_TRIES  (48)
  ) dut (
    .SDR_CLK    (SDR_CLK),
    .RST_N      (RST_N),
    .raw_12bit  (raw_12bit),
    .train_req  (train_req),
    .data_12bit (data_12bit),
    .aligned    (aligned),
    .align_err  (align_err),
    .bit_offset (bit_offset)
  );

  initial SDR_CLK = 1'b0;
  always #5 SDR_CLK = ~SDR_CLK;

  task automatic tick();
    @(posedge SDR_CLK);
    #1;
  endtask

  // Hold a word long enough to fill the two-word history.
  task automatic preload(input logic [11:0] w);
    raw_12bit = w;
    repeat (3) tick();
  endtask

  // Request is sampled on the next edge (edge 0).
  task automatic pulse_train();
    train_req = 1'b1;
    tick();
    train_req = 1'b0;
  endtask

  task automatic test_reset();
    RST_N = 1'b1;
    #2;
    RST_N = 1'b0;
    #1;
    checks++; if (data_12bit !== 12'h000) begin errors++; $display("FAIL reset_data got %h exp 000", data_12bit); end
    checks++; if (aligned !== 1'b0) begin errors++; $display("FAIL reset_aligned got %b exp 0", aligned); end
    checks++; if (align_err !== 1'b0) begin errors++; $display("FAIL reset_err got %b exp 0", align_err); end
    checks++; if (bit_offset !== 4'd0) begin errors++; $display("FAIL reset_offset got %0d exp 0", bit_offset); end
    repeat (2) tick();
    @(negedge SDR_CLK);
    RST_N = 1'b1;
    repeat (3) tick();
    checks++; if (bit_offset !== 4'd0 || aligned !== 1'b0) begin errors++; $display("FAIL reset_idle got off=%0d al=%b exp off=0 al=0", bit_offset, aligned); end
  endtask

  task automatic test_lock_offset5();
    preload(12'hF81);
    pulse_train();
    checks++; if (bit_offset !== 4'd0) begin errors++; $display("FAIL l5_edge0_offset got %0d exp 0", bit_offset); end
    for (int e = 1; e <= 14; e++) begin
      tick();
      if (e <= 5) begin
        checks++; if (bit_offset !== 4'(e)) begin errors++; $display("FAIL l5_step e=%0d got %0d exp %0d", e, bit_offset, e); end
      end
      if (e < 13) begin
        checks++; if (aligned !== 1'b0) begin errors++; $display("FAIL l5_early_aligned e=%0d got %b exp 0", e, aligned); end
      end
      if (e == 13) begin
        checks++; if (aligned !== 1'b1) begin errors++; $display("FAIL l5_lock_edge got %b exp 1", aligned); end
        checks++; if (data_12bit !== 12'h000) begin errors++; $display("FAIL l5_data_at_lock got %h exp 000", data_12bit); end
      end
      if (e == 14) begin
        checks++; if (data_12bit !== 12'h0FC) begin errors++; $display("FAIL l5_data got %h exp 0FC", data_12bit); end
      end
    end
    repeat (5) tick();
    checks++; if (bit_offset !== 4'd5 || aligned !== 1'b1) begin errors++; $display("FAIL l5_hold got off=%0d al=%b exp off=5 al=1", bit_offset, aligned); end
    checks++; if (data_12bit !== 12'h0FC) begin errors++; $display("FAIL l5_hold_data got %h exp 0FC", data_12bit); end
  endtask

  task automatic test_wrap();
    int lock_edge;
    preload(12'h07E);
    pulse_train();
    lock_edge = -1;
    for (int e = 1; e <= 40 && lock_edge < 0; e++) begin
      tick();
      if (aligned === 1'b1) lock_edge = e;
    end
    checks++; if (lock_edge != 19) begin errors++; $display("FAIL wrap11_lock_edge got %0d exp 19", lock_edge); end
    checks++; if (bit_offset !== 4'd11) begin errors++; $display("FAIL wrap11_offset got %0d exp 11", bit_offset); end
    tick();
    checks++; if (data_12bit !== 12'h0FC) begin errors++; $display("FAIL wrap11_data got %h exp 0FC", data_12bit); end

    preload(12'h0FC);
    pulse_train();
    lock_edge = -1;
    for (int e = 1; e <= 40 && lock_edge < 0; e++) begin
      tick();
      if (aligned === 1'b1) lock_edge = e;
    end
    checks++; if (lock_edge != 8) begin errors++; $display("FAIL wrap0_lock_edge got %0d exp 8", lock_edge); end
    checks++; if (bit_offset !== 4'd0) begin errors++; $display("FAIL wrap0_offset got %0d exp 0", bit_offset); end
    tick();
    checks++; if (data_12bit !== 12'h0FC) begin errors++; $display("FAIL wrap0_data got %h exp 0FC", data_12bit); end
  endtask

  task automatic test_no_training();
    preload(12'h000);
    pulse_train();
    repeat (47) tick();
    checks++; if (align_err !== 1'b0) begin errors++; $display("FAIL notrain_early_err got %b exp 0", align_err); end
    tick();
    checks++; if (align_err !== 1'b1) begin errors++; $display("FAIL notrain_err got %b exp 1", align_err); end
    checks++; if (aligned !== 1'b0) begin errors++; $display("FAIL notrain_aligned got %b exp 0", aligned); end
    checks++; if (data_12bit !== 12'h000) begin errors++; $display("FAIL notrain_data got %h exp 000", data_12bit); end
    checks++; if (bit_offset !== 4'd0) begin errors++; $display("FAIL notrain_offset got %0d exp 0", bit_offset); end
    repeat (3) tick();
    checks++; if (align_err !== 1'b1 || bit_offset !== 4'd0) begin errors++; $display("FAIL notrain_hold got err=%b off=%0d exp err=1 off=0", align_err, bit_offset); end
  endtask

  task automatic test_verify_glitch();
    int lock_edge;
    preload(12'hF81);
    pulse_train();
    repeat (7) tick();
    raw_12bit = 12'h000;
    tick();
    raw_12bit = 12'hF81;
    tick();
    checks++; if (bit_offset !== 4'd6) begin errors++; $display("FAIL glitch_offset got %0d exp 6", bit_offset); end
    checks++; if (aligned !== 1'b0) begin errors++; $display("FAIL glitch_aligned got %b exp 0", aligned); end
    lock_edge = -1;
    for (int e = 10; e <= 60 && lock_edge < 0; e++) begin
      tick();
      if (e == 10) begin
        checks++; if (bit_offset !== 4'd7) begin errors++; $display("FAIL glitch_step got %0d exp 7", bit_offset); end
      end
      if (aligned === 1'b1) lock_edge = e;
    end
    checks++; if (lock_edge != 28) begin errors++; $display("FAIL glitch_relock_edge got %0d exp 28", lock_edge); end
    checks++; if (bit_offset !== 4'd5) begin errors++; $display("FAIL glitch_relock_offset got %0d exp 5", bit_offset); end
  endtask

  task automatic test_retrain();
    int lock_edge;
    tick();
    checks++; if (data_12bit !== 12'h0FC) begin errors++; $display("FAIL retrain_pre_data got %h exp 0FC", data_12bit); end
    pulse_train();
    checks++; if (aligned !== 1'b0) begin errors++; $display("FAIL retrain_aligned got %b exp 0", aligned); end
    checks++; if (data_12bit !== 12'h000) begin errors++; $display("FAIL retrain_data got %h exp 000", data_12bit); end
    checks++; if (bit_offset !== 4'd0) begin errors++; $display("FAIL retrain_offset got %0d exp 0", bit_offset); end
    repeat (7) tick();
    checks++; if (bit_offset !== 4'd5 || aligned !== 1'b0) begin errors++; $display("FAIL retrain_verify got off=%0d al=%b exp off=5 al=0", bit_offset, aligned); end
    pulse_train();
    checks++; if (bit_offset !== 4'd0) begin errors++; $display("FAIL retrain_verify_restart got %0d exp 0", bit_offset); end
    lock_edge = -1;
    for (int e = 1; e <= 40 && lock_edge < 0; e++) begin
      tick();
      if (aligned === 1'b1) lock_edge = e;
    end
    checks++; if (lock_edge != 13 || bit_offset !== 4'd5) begin errors++; $display("FAIL retrain_relock got edge=%0d off=%0d exp edge=13 off=5", lock_edge, bit_offset); end
  endtask

  task automatic test_reset_mid();
    int lock_edge;
    preload(12'hF81);
    pulse_train();
    repeat (8) tick();
    checks++; if (bit_offset !== 4'd5) begin errors++; $display("FAIL rstmid_pre_offset got %0d exp 5", bit_offset); end
    #2;
    RST_N = 1'b0;
    #1;
    checks++; if (bit_offset !== 4'd0) begin errors++; $display("FAIL rstmid_offset got %0d exp 0", bit_offset); end
    checks++; if (aligned !== 1'b0 || align_err !== 1'b0 || data_12bit !== 12'h000) begin errors++; $display("FAIL rstmid_outs got al=%b err=%b data=%h exp 0 0 000", aligned, align_err, data_12bit); end
    @(negedge SDR_CLK);
    RST_N = 1'b1;
    repeat (5) tick();
    checks++; if (bit_offset !== 4'd0 || aligned !== 1'b0 || align_err !== 1'b0) begin errors++; $display("FAIL rstmid_idle got off=%0d al=%b err=%b exp 0 0 0", bit_offset, aligned, align_err); end
    pulse_train();
    lock_edge = -1;
    for (int e = 1; e <= 40 && lock_edge < 0; e++) begin
      tick();
      if (aligned === 1'b1) lock_edge = e;
    end
    checks++; if (lock_edge != 13) begin errors++; $display("FAIL rstmid_lock_edge got %0d exp 13", lock_edge); end
    tick();
    #2;
    RST_N = 1'b0;
    #1;
    checks++; if (aligned !== 1'b0 || data_12bit !== 12'h000 || bit_offset !== 4'd0) begin errors++; $display("FAIL rstlock_outs got al=%b data=%h off=%0d exp 0 000 0", aligned, data_12bit, bit_offset); end
    @(negedge SDR_CLK);
    RST_N = 1'b1;
    tick();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    RST_N     = 1'b1;
    raw_12bit = 12'h000;
    train_req = 1'b0;
    test_reset();
    test_lock_offset5();
    test_wrap();
    test_no_training();
    test_verify_glitch();
    test_retrain();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/lvds_bitslip_align.md
# lvds_bitslip_align

Per-channel word-boundary trainer between the LVDS deserializer gearbox and the sync-code word aligner. It takes raw 12-bit words with an unknown bit rotation and finds the rotation by sweeping a bit offset against a known training word. It then freezes the offset and emits correctly framed 12-bit words as `data_12bit` to the word aligner. One instance per LVDS data lane, all in the `SDR_CLK` domain.

## Interface
- `TRAIN_WORD`, 12'h0FC, training pattern sent by the sensor during the training phase; all 12 rotations are distinct.
- `LOCK_COUNT`, 8, consecutive matches needed to declare lock; range 1..255.
- `MAX_TRIES`, 48, offset advances allowed before declaring failure; range 12..255.

- `SDR_CLK`  in  1  word clock, rising edge.
- `RST_N`  in  1  asynchronous, active-low reset.
- `raw_12bit`  in  12  deserializer word; bit 0 is the earliest bit.
- `train_req`  in  1  one-cycle pulse that starts or restarts training.
- `data_12bit`  out  12  aligned word; 12'h000 unless locked.
- `aligned`  out  1  high while in LOCKED.
- `align_err`  out  1  high while in FAIL.
- `bit_offset`  out  4  current offset, 0..11.

## Operation
- Pipeline registers: `raw_q0 <= raw_12bit`, `raw_q1 <= raw_q0`.
- `cat = {raw_q0, raw_q1}` (24 bits). `window = cat[bit_offset+11 : bit_offset]`. For a constant input `R`, `window = ROR(R, bit_offset)`.
- `match = (window == TRAIN_WORD)`.
- Counters:
  - `try_cnt` is 8 bits.
  - `match_cnt` is 8 bits.
  - An advance sets `bit_offset` to `bit_offset==11 ? 0 : bit_offset+1` and increments `try_cnt`. No other wrap value is legal.
- FSM states: IDLE, SEARCH, VERIFY, LOCKED, FAIL.
  - **IDLE:** wait for `train_req`.
  - **SEARCH:**
    - On `match`: go to VERIFY with `match_cnt=1`.
    - Otherwise: advance. If the new `try_cnt` equals `MAX_TRIES`, go to FAIL; else stay in SEARCH.
  - **VERIFY:**
    - On `match`: if `match_cnt+1 == LOCK_COUNT`, go to LOCKED; else increment `match_cnt`.
    - On mismatch: clear `match_cnt`, advance, and go to SEARCH. The FAIL check is the same as in SEARCH.
    - If `LOCK_COUNT==1`, SEARCH goes directly to LOCKED on the first match.
  - **LOCKED:** `bit_offset` is frozen. Mismatches are ignored, because payload is not training data.
  - **FAIL:** `bit_offset` holds its last value.
- A `train_req` pulse in any state forces SEARCH with `bit_offset=0`, `try_cnt=0` and `match_cnt=0`. It takes priority over every other transition in that cycle.
- Output data: `data_12bit <= (state==LOCKED) ? window : 12'h000`. This keeps garbage from producing false SOL/SOF codes downstream.

## Timing
- Reset values: state IDLE, `data_12bit=0`, `aligned=0`, `align_err=0`, `bit_offset=0`, all counters and `raw_q*` equal to 0. Reset takes effect immediately, including mid-training.
- Data latency from `raw_12bit` to `data_12bit` is 3 edges, fixed and independent of offset.
- `aligned`, `align_err` and `bit_offset` are registered state decodes; they change on the edge that changes state.
- Best-case lock: with edge 0 sampling `train_req` and offset k correct, LOCKED is entered at edge k+`LOCK_COUNT`. With defaults and k=5, that is edge 13.
- `data_12bit` carries the aligned word from edge (lock edge + 1).
- Input must be stable for 2 edges before `match` is meaningful. Training mismatches during this fill are simply advances.

## Structure
- Shared package `lvds_rx_pkg` holds:
  - the `DATA_W=12` constant;
  - the `TRAIN_WORD` default;
  - the `align_state_t` enum (IDLE, SEARCH, VERIFY, LOCKED, FAIL);
  - the sync-code constants shared with the word aligner.
- One sub-module, `bit_window_mux`: a combinational 24-to-12 selector indexed by a 4-bit offset. Offsets 12..15 return 12'h000.

## Test plan
- **Lock at offset 5:** `raw_12bit=12'hF81` constant, `train_req` pulse at edge 0.
  - `bit_offset` steps 0..5.
  - `aligned=1` after edge 13.
  - `data_12bit=12'h0FC` after edge 14.
  - `bit_offset` stays 5.
- **Wrap boundaries:**
  - `raw=12'h07E` locks at `bit_offset=11`.
  - `raw=12'h0FC` locks at 0 with `aligned` after edge 8.
- **No training:** `raw=12'h000`, pulse → `align_err=1` after edge 48, `aligned=0`, `data_12bit=0`, `bit_offset=0`. This is 48 advances, i.e. 4 wraps.
- **VERIFY glitch:** at `raw=12'hF81`, inject one `12'h000` word two edges after VERIFY entry.
  - The FSM returns to SEARCH with `bit_offset=6`.
  - It relocks at offset 5 after wrapping.
  - `aligned` is never high before relock.
- **Retrain:** a `train_req` pulse while LOCKED drops `aligned` and `data_12bit` to 0 on the next edge and sets `bit_offset=0`. A second `train_req` pulse during VERIFY also restarts at offset 0.
- **Reset mid-operation:** assert `RST_N=0` asynchronously during VERIFY. All outputs take their reset values before the next clock edge. After release, the FSM stays in IDLE until `train_req`.
